// File: rtl/fpu_req_pkg.sv
// Shared types for the FPU request sequencer: FSM states, transfer descriptor
// and line geometry.
package fpu_req_pkg;

    localparam int D_ADDR_W   = 32;
    localparam int D_WIDTH_W  = 10;
    localparam int D_HEIGHT_W = 5;
    localparam int D_STRIDE_W = 19;

    localparam int LINE_SIZE         = 64;
    localparam int LINE_SHIFT        = $clog2(LINE_SIZE);
    localparam int MAX_LINES_PER_ROW = 512 / LINE_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        WR_LAST,
        RD_LAST
    } state_t;

    typedef struct packed {
        logic [D_ADDR_W-1:0]   base;
        logic [D_WIDTH_W-1:0]  width;
        logic [D_HEIGHT_W-1:0] height;
        logic [D_STRIDE_W-1:0] stride;
    } desc_t;

endpackage

// File: rtl/fpu_rect_walker.sv
// Walks a height x width rectangle one memory line at a time: row/line
// counters, accumulated row base address and the per-line byte mask.
module fpu_rect_walker #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int LINE_BYTES       = 64,
    parameter int ADDR_W           = 32,
    parameter int STRIDE_W         = 19
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            load,
    input  logic                                            advance,
    input  logic [ADDR_W-1:0]                               base,
    input  logic [$clog2(MEM_BUFFER_WIDTH):0]               width,
    input  logic [$clog2(COL_WIDTH):0]                      height,
    input  logic [STRIDE_W-1:0]                             stride,
    output logic [ADDR_W-1:0]                               addr,
    output logic [LINE_BYTES-1:0]                           byte_en,
    output logic [$clog2(COL_WIDTH)-1:0]                    row,
    output logic [$clog2(MEM_BUFFER_WIDTH/LINE_BYTES)-1:0]  line,
    output logic                                            last
);

    localparam int WIDTH_W  = $clog2(MEM_BUFFER_WIDTH) + 1;
    localparam int HEIGHT_W = $clog2(COL_WIDTH) + 1;
    localparam int LSH      = $clog2(LINE_BYTES);

    logic [ADDR_W-1:0]     row_base;
    logic [WIDTH_W-1:0]    lines_per_row;
    logic [LSH-1:0]        rem;
    logic [LINE_BYTES-1:0] tail_mask;
    logic                  last_line;
    logic                  last_row;

    assign lines_per_row = (width + WIDTH_W'(LINE_BYTES - 1)) >> LSH;
    assign last_line     = (WIDTH_W'(line) == lines_per_row - WIDTH_W'(1));
    assign last_row      = (HEIGHT_W'(row) == height - HEIGHT_W'(1));
    assign last          = last_line && last_row;

    // A partial final line enables only the low (width mod LINE_BYTES) bytes.
    assign rem       = width[LSH-1:0];
    assign tail_mask = (LINE_BYTES'(1) << rem) - LINE_BYTES'(1);
    assign byte_en   = (last_line && rem != '0) ? tail_mask : '1;

    assign addr = row_base + (ADDR_W'(line) << LSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
            row      <= '0;
            line     <= '0;
        end else if (load) begin
            row_base <= base;
            row      <= '0;
            line     <= '0;
        end else if (advance) begin
            if (last_line) begin
                line     <= '0;
                row      <= row + 1'b1;
                row_base <= row_base + ADDR_W'(stride);
            end else begin
                line     <= line + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_req_sequencer.sv
// Turns FPU chunk-level read/write requests into line-sized memory
// transactions; writes drain before reads fill.
module fpu_req_sequencer
    import fpu_req_pkg::*;
#(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    parameter int LINE_BYTES       = LINE_SIZE,
    parameter int ADDR_W           = 32
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            read,
    input  logic                                            write,
    input  logic [ADDR_W-1:0]                               read_address,
    input  logic [ADDR_W-1:0]                               write_address,
    input  logic [$clog2(MEM_BUFFER_WIDTH):0]               width,
    input  logic [$clog2(COL_WIDTH):0]                      height,
    input  logic [18:0]                                     row_stride,
    output logic                                            making_request,
    output logic                                            mem_req,
    output logic                                            mem_we,
    output logic [ADDR_W-1:0]                               mem_addr,
    output logic [LINE_BYTES-1:0]                           mem_byte_en,
    input  logic                                            mem_ready,
    input  logic                                            mem_rdata_valid,
    output logic [$clog2(COL_WIDTH)-1:0]                    buf_row,
    output logic [$clog2(MEM_BUFFER_WIDTH/LINE_BYTES)-1:0]  buf_line,
    output logic                                            rd_buf_we,
    output logic                                            wr_buf_re,
    output logic                                            overrun
);

    localparam int ROW_W  = $clog2(COL_WIDTH);
    localparam int LINE_W = $clog2(MEM_BUFFER_WIDTH / LINE_BYTES);

    state_t state, state_n;
    desc_t  rd_desc, wr_desc, walk_desc;
    logic   rd_pend, wr_pend;
    logic   rd_busy, wr_busy, rd_accept, wr_accept;
    logic   use_wr, zero_size, load, advance, buf_active;

    logic [ADDR_W-1:0]     walk_addr;
    logic [LINE_BYTES-1:0] walk_be;
    logic [ROW_W-1:0]      walk_row;
    logic [LINE_W-1:0]     walk_line;
    logic                  walk_last;

    // The *_LAST cycle retires its descriptor, so a same-type pulse there is new work.
    assign rd_busy   = rd_pend && (state != RD_LAST);
    assign wr_busy   = wr_pend && (state != WR_LAST);
    assign rd_accept = read && !rd_busy;
    assign wr_accept = write && !wr_busy;

    assign use_wr    = (state == IDLE) ? wr_pend : (state == WR_ISSUE || state == WR_LAST);
    assign walk_desc = use_wr ? wr_desc : rd_desc;
    assign zero_size = (walk_desc.width == '0) || (walk_desc.height == '0);

    assign making_request = read | write | rd_pend | wr_pend | (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_pend <= 1'b0;
            wr_pend <= 1'b0;
            rd_desc <= '0;
            wr_desc <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            if (rd_accept)
                rd_desc <= '{base: read_address, width: width, height: height, stride: row_stride};
            if (wr_accept)
                wr_desc <= '{base: write_address, width: width, height: height, stride: row_stride};
            rd_pend <= rd_accept ? 1'b1 : ((state == RD_LAST) ? 1'b0 : rd_pend);
            wr_pend <= wr_accept ? 1'b1 : ((state == WR_LAST) ? 1'b0 : wr_pend);
            if ((read && rd_busy) || (write && wr_busy))
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        wr_buf_re  = 1'b0;
        rd_buf_we  = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        buf_active = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    load    = 1'b1;
                    state_n = zero_size ? WR_LAST : WR_ISSUE;
                end else if (rd_pend) begin
                    load    = 1'b1;
                    state_n = zero_size ? RD_LAST : RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                wr_buf_re  = 1'b1;
                buf_active = 1'b1;
                if (mem_ready) begin
                    advance = 1'b1;
                    if (walk_last)
                        state_n = WR_LAST;
                end
            end
            RD_ISSUE: begin
                mem_req    = 1'b1;
                buf_active = 1'b1;
                if (mem_ready)
                    state_n = RD_WAIT;
            end
            RD_WAIT: begin
                buf_active = 1'b1;
                if (mem_rdata_valid) begin
                    rd_buf_we = 1'b1;
                    advance   = 1'b1;
                    state_n   = walk_last ? RD_LAST : RD_ISSUE;
                end
            end
            WR_LAST, RD_LAST: state_n = IDLE;
            default:          state_n = IDLE;
        endcase
    end

    assign mem_addr    = mem_req ? walk_addr : '0;
    assign mem_byte_en = mem_req ? walk_be : '0;
    assign buf_row     = buf_active ? walk_row : '0;
    assign buf_line    = buf_active ? walk_line : '0;

    fpu_rect_walker #(
        .COL_WIDTH        (COL_WIDTH),
        .MEM_BUFFER_WIDTH (MEM_BUFFER_WIDTH),
        .LINE_BYTES       (LINE_BYTES),
        .ADDR_W           (ADDR_W),
        .STRIDE_W         (19)
    ) u_walker (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .base    (walk_desc.base),
        .width   (walk_desc.width),
        .height  (walk_desc.height),
        .stride  (walk_desc.stride),
        .addr    (walk_addr),
        .byte_en (walk_be),
        .row     (walk_row),
        .line    (walk_line),
        .last    (walk_last)
    );

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Bench for fpu_req_sequencer: directed scenarios plus random rectangles,
// checked against a rectangle-walk reference model and a memory responder.
module tb_fpu_req_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        read, write;
    logic [31:0] read_address, write_address;
    logic [9:0]  width;
    logic [4:0]  height;
    logic [18:0] row_stride;
    logic        making_request, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_byte_en;
    logic        mem_ready, mem_rdata_valid;
    logic [3:0]  buf_row;
    logic [2:0]  buf_line;
    logic        rd_buf_we, wr_buf_re, overrun;

    always #5 clk = ~clk;

    fpu_req_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .read            (read),
        .write           (write),
        .read_address    (read_address),
        .write_address   (write_address),
        .width           (width),
        .height          (height),
        .row_stride      (row_stride),
        .making_request  (making_request),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_byte_en     (mem_byte_en),
        .mem_ready       (mem_ready),
        .mem_rdata_valid (mem_rdata_valid),
        .buf_row         (buf_row),
        .buf_line        (buf_line),
        .rd_buf_we       (rd_buf_we),
        .wr_buf_re       (wr_buf_re),
        .overrun         (overrun)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [63:0] be;
        logic [3:0]  row;
        logic [2:0]  line;
    } txn_t;

    txn_t exp_q[$];
    txn_t rd_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cfg_stall = 0;
    int   cfg_lat   = 2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: every line of the rectangle in row-major order, address by plain arithmetic.
    task automatic expect_rect(input bit we, input logic [31:0] base, input int w, input int h, input int s);
        int lines;
        txn_t t;
        lines = (w + 63) / 64;
        for (int r = 0; r < h; r++) begin
            for (int l = 0; l < lines; l++) begin
                t.addr = base + 32'(r * s) + 32'(l * 64);
                t.we   = we;
                t.be   = (l == lines - 1 && (w % 64) != 0) ? ((64'h1 << (w % 64)) - 64'h1) : {64{1'b1}};
                t.row  = 4'(r);
                t.line = 3'(l);
                exp_q.push_back(t);
                if (!we) rd_q.push_back(t);
            end
        end
    endtask

    task automatic pulse(input bit do_rd, input bit do_wr, input logic [31:0] ra, input logic [31:0] wa,
                         input int w, input int h, input int s);
        @(negedge clk);
        read_address  = ra;
        write_address = wa;
        width         = 10'(w);
        height        = 5'(h);
        row_stride    = 19'(s);
        read          = do_rd;
        write         = do_wr;
        #1 check("mr_in_pulse", {63'd0, making_request}, 64'd1);
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (making_request === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {63'd0, n < budget}, 64'd1);
        check({tag, "_txn_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_rd_left"}, 64'(rd_q.size()), 64'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"}, {53'd0, making_request, mem_req, mem_we, rd_buf_we, wr_buf_re, overrun,
                               buf_row, buf_line}, 64'd0);
        check({tag, "_addr"}, {32'd0, mem_addr}, 64'd0);
        check({tag, "_be"}, mem_byte_en, 64'd0);
    endtask

    // Memory side: accepts after a configurable stall, returns read data after a latency,
    // and checks every transaction and every read-buffer write against the model.
    initial begin : responder
        bit          in_req, stalled, acc, acc_we;
        int          stall_left, rd_cnt;
        logic [31:0] p_addr;
        logic        p_we;
        logic [63:0] p_be;
        txn_t        t;
        in_req = 0; stalled = 0; acc = 0; acc_we = 0; stall_left = 0; rd_cnt = 0;
        p_addr = '0; p_we = 1'b0; p_be = '0;
        mem_ready = 1'b0;
        mem_rdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_req = 0; stalled = 0; acc = 0; stall_left = 0; rd_cnt = 0;
                mem_ready = 1'b0;
                mem_rdata_valid = 1'b0;
            end else begin
                if (acc) begin
                    in_req = 0;
                    if (!acc_we) rd_cnt = (cfg_lat < 0) ? int'($urandom_range(1, 3)) : cfg_lat;
                    acc = 0;
                end
                mem_rdata_valid = 1'b0;
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) mem_rdata_valid = 1'b1;
                end
                if (mem_req && !in_req) begin
                    in_req = 1;
                    stall_left = (cfg_stall < 0) ? int'($urandom_range(0, 3)) : cfg_stall;
                end
                if (mem_req && stall_left == 0) mem_ready = 1'b1;
                else begin
                    mem_ready = 1'b0;
                    if (mem_req) stall_left--;
                end
                #1;
                if (stalled) begin
                    check("hold_req", {63'd0, mem_req}, 64'd1);
                    check("hold_addr", {32'd0, mem_addr}, {32'd0, p_addr});
                    check("hold_we", {63'd0, mem_we}, {63'd0, p_we});
                    check("hold_be", mem_byte_en, p_be);
                end
                stalled = mem_req && !mem_ready;
                p_addr = mem_addr; p_we = mem_we; p_be = mem_byte_en;
                if (mem_req && mem_ready) begin
                    acc = 1;
                    acc_we = mem_we;
                    check("txn_expected", {63'd0, exp_q.size() > 0}, 64'd1);
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        check("txn_addr", {32'd0, mem_addr}, {32'd0, t.addr});
                        check("txn_be", mem_byte_en, t.be);
                        check("txn_ctl", {55'd0, mem_we, wr_buf_re, buf_row, buf_line},
                              {55'd0, t.we, t.we, t.row, t.line});
                    end
                end
                if (rd_buf_we) begin
                    check("rdwe_expected", {63'd0, rd_q.size() > 0}, 64'd1);
                    if (rd_q.size() > 0) begin
                        t = rd_q.pop_front();
                        check("rdwe_row_line", {57'd0, buf_row, buf_line}, {57'd0, t.row, t.line});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int mode, w, h, s;
        logic [31:0] ra, wa;
        rst = 1'b1; read = 1'b0; write = 1'b0;
        read_address = '0; write_address = '0; width = '0; height = '0; row_stride = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;

        // Read 128 x 2 with immediate ready and 2-cycle data return.
        cfg_stall = 0; cfg_lat = 2;
        expect_rect(1'b0, 32'h1000, 128, 2, 32'h600);
        pulse(1'b1, 1'b0, 32'h1000, 32'h0, 128, 2, 32'h600);
        wait_idle("rd_128x2", 200);

        // Write 100 x 1: second line carries a 36-byte mask.
        expect_rect(1'b1, 32'h2000, 100, 1, 32'h0);
        pulse(1'b0, 1'b1, 32'h0, 32'h2000, 100, 1, 0);
        wait_idle("wr_100x1", 200);

        // Simultaneous read and write: whole write drains before the read starts.
        expect_rect(1'b1, 32'h5000, 192, 2, 32'h300);
        expect_rect(1'b0, 32'h7000, 192, 2, 32'h300);
        pulse(1'b1, 1'b1, 32'h7000, 32'h5000, 192, 2, 32'h300);
        wait_idle("both", 400);

        // Five-cycle ready stall on every transaction.
        cfg_stall = 5;
        expect_rect(1'b1, 32'h4000, 128, 1, 0);
        pulse(1'b0, 1'b1, 32'h0, 32'h4000, 128, 1, 0);
        wait_idle("stall5", 200);
        cfg_stall = 0;

        // Second read pulse while reading: flagged, otherwise ignored.
        cfg_lat = 3;
        expect_rect(1'b0, 32'h3000, 64, 3, 32'h100);
        pulse(1'b1, 1'b0, 32'h3000, 32'h0, 64, 3, 32'h100);
        check("ovr_before", {63'd0, overrun}, 64'd0);
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 32'h9000, 32'h0, 256, 4, 32'h40);
        check("ovr_set", {63'd0, overrun}, 64'd1);
        wait_idle("ovr", 300);
        check("ovr_sticky", {63'd0, overrun}, 64'd1);

        // Zero width: busy for two cycles after the pulse, never touches memory.
        pulse(1'b1, 1'b0, 32'hA000, 32'h0, 0, 3, 32'h40);
        check("zero_mr1", {62'd0, making_request, mem_req}, 64'd2);
        @(negedge clk);
        check("zero_mr2", {62'd0, making_request, mem_req}, 64'd2);
        @(negedge clk);
        check("zero_mr3", {62'd0, making_request, mem_req}, 64'd0);

        // Reset in the middle of a large read.
        cfg_stall = -1; cfg_lat = -1;
        expect_rect(1'b0, 32'hFFFF_F000, 512, 10, 32'h7_FFC0);
        pulse(1'b1, 1'b0, 32'hFFFF_F000, 32'h0, 512, 10, 32'h7_FFC0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("midrst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rd_q.delete();

        // Random rectangles, random stalls and latencies.
        for (int it = 0; it < 20; it++) begin
            mode = int'($urandom_range(0, 2));
            w    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 512));
            h    = int'($urandom_range(0, 10));
            s    = int'($urandom_range(0, 19'h7FFFF));
            ra   = $urandom;
            wa   = $urandom;
            if (mode != 0) expect_rect(1'b1, wa, w, h, s);
            if (mode != 1) expect_rect(1'b0, ra, w, h, s);
            pulse(mode != 1, mode != 0, ra, wa, w, h, s);
            wait_idle("rand", 5000);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
